// File: rtl/key_expander.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | key_expander: expands a master key into ROUNDS round keys over PASSES     |
// | passes of an external block-cipher engine on AXI-stream. Rev 1.0 initial. |
// +--------------------------------------------------------------------------+
module key_expander #(
  parameter  int BLOCK_W = 64,
  parameter  int ROUNDS  = 32,
  parameter  int PASSES  = 2,
  localparam int RK_W    = 3 * BLOCK_W / 4,
  localparam int AW      = $clog2(ROUNDS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PASSES*BLOCK_W-1:0] key,
  input  logic                      key_load,
  output logic [BLOCK_W-1:0]        m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic [BLOCK_W-1:0]        s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [AW-1:0]             rk_addr,
  output logic [RK_W-1:0]           rk_data,
  output logic                      key_ready,
  output logic                      busy
);

  localparam int              PW        = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int              KW        = PASSES * BLOCK_W;
  localparam logic [AW-1:0]   CNT_LAST  = AW'(ROUNDS - 1);
  localparam logic [PW-1:0]   PASS_LAST = PW'(PASSES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      key_q, key_d;
  logic [BLOCK_W-1:0] block_q, block_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic [PW-1:0]      pass_q, pass_d;
  logic [RK_W-1:0]    k_q [ROUNDS];
  logic [RK_W-1:0]    k_d [ROUNDS];
  logic [RK_W-1:0]    rk_data_q, rk_data_d;
  logic               m_valid_q, m_valid_d;
  logic               s_ready_q, s_ready_d;
  logic               key_ready_q, key_ready_d;
  logic               busy_q, busy_d;
  logic [RK_W-1:0]    rk_new;
  logic [BLOCK_W-1:0] next_chunk;

  assign rk_new = {s_axis_tdata[BLOCK_W/4-1:0], s_axis_tdata[BLOCK_W-1:BLOCK_W/2]};

  // Seed block for the following pass: the next-lower BLOCK_W slice of key_q.
  always_comb begin
    next_chunk = '0;
    if (pass_q != PASS_LAST) begin
      next_chunk = key_q[(PASSES - 2 - int'(pass_q)) * BLOCK_W +: BLOCK_W];
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    block_d = block_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    k_d     = k_q;

    case (state_q)
      SEND: begin
        if (m_axis_tready) state_d = WAIT;
      end
      WAIT: begin
        if (s_axis_tvalid) begin
          k_d[cnt_q] = (pass_q == '0) ? rk_new : (k_q[cnt_q] ^ rk_new);
          block_d    = s_axis_tdata;
          if (cnt_q != CNT_LAST) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = SEND;
          end else if (pass_q != PASS_LAST) begin
            pass_d  = pass_q + 1'b1;
            cnt_d   = '0;
            block_d = next_chunk;
            state_d = SEND;
          end else begin
            state_d = DONE;
          end
        end
      end
      default: ;
    endcase

    // A load wins over everything, including a result beat accepted this cycle.
    if (key_load) begin
      key_d   = key;
      block_d = key[KW-1 -: BLOCK_W];
      pass_d  = '0;
      cnt_d   = '0;
      k_d     = k_q;
      state_d = SEND;
    end

    m_valid_d   = (state_d == SEND);
    s_ready_d   = (state_d == WAIT);
    busy_d      = (state_d == SEND) || (state_d == WAIT);
    key_ready_d = (state_d == DONE);
    rk_data_d   = (int'(rk_addr) < ROUNDS) ? k_q[rk_addr] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      key_q       <= '0;
      block_q     <= '0;
      cnt_q       <= '0;
      pass_q      <= '0;
      for (int i = 0; i < ROUNDS; i++) k_q[i] <= '0;
      rk_data_q   <= '0;
      m_valid_q   <= 1'b0;
      s_ready_q   <= 1'b0;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      block_q     <= block_d;
      cnt_q       <= cnt_d;
      pass_q      <= pass_d;
      k_q         <= k_d;
      rk_data_q   <= rk_data_d;
      m_valid_q   <= m_valid_d;
      s_ready_q   <= s_ready_d;
      key_ready_q <= key_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign m_axis_tdata  = block_q;
  assign m_axis_tvalid = m_valid_q;
  assign s_axis_tready = s_ready_q;
  assign rk_data       = rk_data_q;
  assign key_ready     = key_ready_q;
  assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_key_expander.sv
`default_nettype none
// Bench for key_expander: +1 mock engine (optional stalls), scoreboarded round-key reads.
module tb_key_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [127:0] a_key;
  logic         a_load;
  logic [63:0]  a_m_tdata, a_s_tdata;
  logic         a_m_tvalid, a_m_tready, a_s_tvalid, a_s_tready;
  logic [4:0]   a_rk_addr;
  logic [47:0]  a_rk_data;
  logic         a_key_ready, a_busy;

  logic [95:0]  b_key;
  logic         b_load;
  logic [31:0]  b_m_tdata, b_s_tdata;
  logic         b_m_tvalid, b_m_tready, b_s_tvalid, b_s_tready;
  logic [2:0]   b_rk_addr;
  logic [23:0]  b_rk_data;
  logic         b_key_ready, b_busy;

  key_expander u_a (
    .clk(clk), .rst(rst), .key(a_key), .key_load(a_load),
    .m_axis_tdata(a_m_tdata), .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready),
    .s_axis_tdata(a_s_tdata), .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
    .rk_addr(a_rk_addr), .rk_data(a_rk_data), .key_ready(a_key_ready), .busy(a_busy)
  );

  key_expander #(.BLOCK_W(32), .ROUNDS(8), .PASSES(3)) u_b (
    .clk(clk), .rst(rst), .key(b_key), .key_load(b_load),
    .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready),
    .s_axis_tdata(b_s_tdata), .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
    .rk_addr(b_rk_addr), .rk_data(b_rk_data), .key_ready(b_key_ready), .busy(b_busy)
  );

  int          checks = 0;
  int          errors = 0;
  int          m_count, s_count, stall_viol, stall_seen;
  bit          stall_en, hold;
  bit          a_have, b_have;
  logic [63:0] a_res;
  logic [31:0] b_res;
  int          a_dly, a_mst;
  bit          rd_a, rd_b;
  logic [47:0] qa[$];
  logic [23:0] qb[$];
  string       rd_tag;
  logic [47:0] exp_k [32];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reference schedule for the default instance with a +1 engine.
  task automatic model_a(input logic [127:0] k);
    logic [63:0] b;
    for (int i = 0; i < 32; i++) exp_k[i] = '0;
    for (int p = 0; p < 2; p++) begin
      b = (p == 0) ? k[127:64] : k[63:0];
      for (int i = 0; i < 32; i++) begin
        b = b + 64'd1;
        exp_k[i] = exp_k[i] ^ {b[15:0], b[63:32]};
      end
    end
  endtask

  // One clock: handshakes seen before the edge are applied after it, then engines re-driven.
  task automatic step();
    bit hm, hs, st, ra, rb, bhm, bhs;
    logic [63:0] md;
    logic [31:0] bmd;
    hm  = a_m_tvalid && a_m_tready;
    hs  = a_s_tvalid && a_s_tready;
    st  = a_m_tvalid && !a_m_tready && !a_load && rst;
    md  = a_m_tdata;
    bhm = b_m_tvalid && b_m_tready;
    bhs = b_s_tvalid && b_s_tready;
    bmd = b_m_tdata;
    ra  = rd_a;
    rb  = rd_b;
    rd_a = 1'b0;
    rd_b = 1'b0;
    @(negedge clk);
    if (st) begin
      stall_seen++;
      if (!a_m_tvalid || a_m_tdata !== md) stall_viol++;
    end
    if (ra) chk(rd_tag, 64'(a_rk_data), 64'(qa.pop_front()));
    if (rb) chk(rd_tag, 64'(b_rk_data), 64'(qb.pop_front()));
    if (hs) begin
      a_have = 1'b0;
      s_count++;
    end
    if (hm) begin
      a_have = 1'b1;
      a_res  = md + 64'd1;
      m_count++;
      a_dly  = stall_en ? int'($urandom_range(0, 5)) : 0;
      a_mst  = stall_en ? int'($urandom_range(0, 5)) : 0;
    end
    if (a_have && a_dly == 0) begin
      a_s_tvalid = 1'b1;
      a_s_tdata  = a_res;
    end else begin
      a_s_tvalid = 1'b0;
      a_s_tdata  = {$urandom, $urandom};
      if (a_have) a_dly--;
    end
    if (a_mst > 0) begin
      a_m_tready = 1'b0;
      a_mst--;
    end else begin
      a_m_tready = !a_have && !(hold && m_count == 32);
    end
    if (bhs) b_have = 1'b0;
    if (bhm) begin
      b_have = 1'b1;
      b_res  = bmd + 32'd1;
    end
    b_s_tvalid = b_have;
    b_s_tdata  = b_have ? b_res : $urandom;
    b_m_tready = !b_have;
  endtask

  task automatic read_a(input int i, input logic [47:0] e);
    a_rk_addr = 5'(i);
    qa.push_back(e);
    rd_a = 1'b1;
    step();
  endtask

  task automatic read_b(input int i, input logic [23:0] e);
    b_rk_addr = 3'(i);
    qb.push_back(e);
    rd_b = 1'b1;
    step();
  endtask

  task automatic run_a(input logic [127:0] k, output int n);
    a_key   = k;
    a_load  = 1'b1;
    m_count = 0;
    s_count = 0;
    n       = 0;
    do begin
      step();
      n++;
      a_load = 1'b0;
    end while (!a_key_ready && n < 4000);
  endtask

  initial begin
    int n, seen;
    logic [127:0] k1, k2;
    rst = 1'b1;
    a_key = '0; a_load = 1'b0; a_m_tready = 1'b0; a_s_tvalid = 1'b0; a_s_tdata = '0; a_rk_addr = '0;
    b_key = '0; b_load = 1'b0; b_m_tready = 1'b0; b_s_tvalid = 1'b0; b_s_tdata = '0; b_rk_addr = '0;
    m_count = 0; s_count = 0; stall_viol = 0; stall_seen = 0;
    stall_en = 1'b0; hold = 1'b0; a_have = 1'b0; b_have = 1'b0;
    a_res = '0; b_res = '0; a_dly = 0; a_mst = 0; rd_a = 1'b0; rd_b = 1'b0;
    #1 rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();

    // Reset asserted in the middle of an expansion
    run_a({$urandom, $urandom, $urandom, $urandom}, n);
    a_key = {$urandom, $urandom, $urandom, $urandom};
    a_load = 1'b1; step(); a_load = 1'b0;
    repeat (50) step();
    rst = 1'b0;
    #1;
    chk("rst_m_tvalid", 64'(a_m_tvalid), 64'd0);
    chk("rst_s_tready", 64'(a_s_tready), 64'd0);
    chk("rst_key_ready", 64'(a_key_ready), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_rk_data", 64'(a_rk_data), 64'd0);
    chk("rst_m_tdata", a_m_tdata, 64'd0);
    a_have = 1'b0; a_mst = 0; a_dly = 0; a_s_tvalid = 1'b0;
    step(); step();
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen += int'(a_m_tvalid) + int'(a_busy) + int'(a_key_ready) + int'(a_s_tready);
    end
    chk("idle_activity", 64'(seen), 64'd0);
    rd_tag = "rst_rk";
    for (int i = 0; i < 32; i++) read_a(i, 48'h0);

    // key=0: freeze the engine after pass 0 to inspect partial keys
    hold = 1'b1; a_key = '0; a_load = 1'b1; m_count = 0; s_count = 0;
    step(); a_load = 1'b0;
    n = 0;
    while (!(m_count == 32 && !a_have && a_m_tvalid) && n < 1000) begin step(); n++; end
    chk("hold_busy", 64'(a_busy), 64'd1);
    chk("hold_ready", 64'(a_key_ready), 64'd0);
    rd_tag = "pass0_rk";
    for (int i = 0; i < 32; i++) read_a(i, {16'(i + 1), 32'h0});
    hold = 1'b0;
    n = 0;
    while (!a_key_ready && n < 1000) begin step(); n++; end
    chk("k0_ready", 64'(a_key_ready), 64'd1);
    rd_tag = "k0_rk";
    for (int i = 0; i < 32; i++) read_a(i, 48'h0);

    // Zero-wait engine, second chunk FFFF_0000_0000_0000
    run_a({64'h0, 64'hFFFF_0000_0000_0000}, n);
    chk("zw_latency", 64'(n), 64'd129);
    chk("zw_m_hs", 64'(m_count), 64'd64);
    chk("zw_s_hs", 64'(s_count), 64'd64);
    rd_tag = "ffff_rk";
    for (int i = 0; i < 32; i++) read_a(i, 48'h0000_FFFF_0000);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen += int'(a_m_tvalid) + int'(a_busy) + int'(!a_key_ready);
    end
    chk("done_hold", 64'(seen), 64'd0);

    // Random back-pressure on both channels
    k1 = {$urandom, $urandom, $urandom, $urandom};
    model_a(k1);
    stall_en = 1'b1;
    run_a(k1, n);
    stall_en = 1'b0;
    chk("bp_ready", 64'(a_key_ready), 64'd1);
    chk("bp_m_hs", 64'(m_count), 64'd64);
    chk("bp_s_hs", 64'(s_count), 64'd64);
    chk("bp_stable", 64'(stall_viol), 64'd0);
    rd_tag = "bp_rk";
    for (int i = 0; i < 32; i++) read_a(i, exp_k[i]);

    // Rekey on the pass-1 round-10 result beat
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    model_a(k2);
    a_key = k1; a_load = 1'b1; m_count = 0; s_count = 0;
    step(); a_load = 1'b0;
    n = 0;
    while (!(s_count == 42 && a_s_tvalid && a_s_tready) && n < 1000) begin step(); n++; end
    chk("rekey_point", 64'(s_count), 64'd42);
    run_a(k2, n);
    chk("rekey_latency", 64'(n), 64'd129);
    chk("rekey_m_hs", 64'(m_count), 64'd64);
    chk("rekey_s_hs", 64'(s_count), 64'd65);
    rd_tag = "rekey_rk";
    for (int i = 0; i < 32; i++) read_a(i, exp_k[i]);

    // Small instance: ROUNDS=8, PASSES=3, BLOCK_W=32, key=0
    b_key = '0; b_load = 1'b1; n = 0;
    do begin
      step();
      n++;
      b_load = 1'b0;
    end while (!b_key_ready && n < 1000);
    chk("b_latency", 64'(n), 64'd49);
    rd_tag = "b_rk";
    for (int i = 0; i < 8; i++) read_b(i, {8'(i + 1), 16'h0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
